// File: rtl/lane_pattern_sched_pkg.sv
// Shared encodings for the lane pattern scheduler and its BBCBC step engine.
// Symbol sequence detected: 0,0,1,0,1 (Bike=0, Car=1).
package lane_pattern_sched_pkg;

    localparam int unsigned PAT_LEN = 5;

    localparam logic SYM_BIKE = 1'b0;
    localparam logic SYM_CAR  = 1'b1;

    // One state per matched prefix length, so PAT_LEN sets the state width.
    typedef enum logic [$clog2(PAT_LEN)-1:0] {
        S_IDLE = 3'd0,
        S_B    = 3'd1,
        S_BB   = 3'd2,
        S_BBC  = 3'd3,
        S_BBCB = 3'd4
    } lane_state_e;

endpackage

// File: rtl/lane_pattern_sched_pattern_step.sv
// Single BBCBC transition table: (cur_state, sym) -> (next_state, hit).
// Purely combinational so any detector can share one instance across contexts.
module pattern_step
    import lane_pattern_sched_pkg::*;
(
    input  logic [2:0] cur_state,
    input  logic       sym,
    output logic [2:0] next_state,
    output logic       hit
);

    always_comb begin
        next_state = S_IDLE;
        hit        = 1'b0;
        case (cur_state)
            S_IDLE: next_state = (sym == SYM_BIKE) ? S_B    : S_IDLE;
            S_B:    next_state = (sym == SYM_BIKE) ? S_BB   : S_IDLE;
            S_BB:   next_state = (sym == SYM_BIKE) ? S_BB   : S_BBC;
            S_BBC:  next_state = (sym == SYM_BIKE) ? S_BBCB : S_IDLE;
            S_BBCB: begin
                // Trailing Car leaves no reusable prefix; trailing Bike keeps "BB".
                if (sym == SYM_BIKE) begin
                    next_state = S_BB;
                end else begin
                    next_state = S_IDLE;
                    hit        = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/lane_pattern_sched.sv
// Time-shares one BBCBC step engine between NUM_LANES sensor streams using
// per-lane one-entry hold registers, saved contexts and a round-robin arbiter.
module lane_pattern_sched
    import lane_pattern_sched_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LANE_W    = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] lane_valid,
    input  logic [NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0] lane_ready,
    input  logic [NUM_LANES-1:0] lane_clr,
    output logic                 det_valid,
    output logic [LANE_W-1:0]    det_lane,
    output logic [CNT_W-1:0]     det_count
);

    logic [NUM_LANES-1:0] hold_full;
    logic [NUM_LANES-1:0] hold_sym;
    lane_state_e          ctx [NUM_LANES];
    logic [LANE_W-1:0]    rr_ptr;

    logic [NUM_LANES-1:0] req;
    logic [NUM_LANES-1:0] grant;
    logic [NUM_LANES-1:0] transfer;
    logic [LANE_W-1:0]    gidx;
    logic                 gvalid;
    logic [2:0]           step_next;
    logic                 step_hit;

    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] base,
                                                   input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return LANE_W'(s % NUM_LANES);
    endfunction

    // A lane being cleared is never eligible, so clear always wins over a step.
    assign req = hold_full & ~lane_clr;

    always_comb begin
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (!gvalid && req[lane_add(rr_ptr, k)]) begin
                gvalid = 1'b1;
                gidx   = lane_add(rr_ptr, k);
            end
        end
        grant[gidx] = gvalid;
    end

    assign lane_ready = {NUM_LANES{rst}} & ~lane_clr & (~hold_full | grant);
    assign transfer   = lane_valid & lane_ready;

    pattern_step u_step (
        .cur_state  (ctx[gidx]),
        .sym        (hold_sym[gidx]),
        .next_state (step_next),
        .hit        (step_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_full <= '0;
            hold_sym  <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                ctx[i] <= S_IDLE;
            end
            rr_ptr    <= '0;
            det_valid <= 1'b0;
            det_lane  <= '0;
            det_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (lane_clr[i]) begin
                    ctx[i]       <= S_IDLE;
                    hold_full[i] <= 1'b0;
                end else if (transfer[i]) begin
                    hold_full[i] <= 1'b1;
                    hold_sym[i]  <= lane_data[i];
                end else if (grant[i]) begin
                    hold_full[i] <= 1'b0;
                end
            end

            if (gvalid) begin
                ctx[gidx] <= lane_state_e'(step_next);
                rr_ptr    <= lane_add(gidx, 1);
            end

            det_valid <= gvalid & step_hit;
            if (gvalid && step_hit) begin
                det_lane <= gidx;
                if (det_count != '1) begin
                    det_count <= det_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_pattern_sched.sv
// Scoreboard bench: stimulus pushes expected detections, a monitor pops them.
module tb_lane_pattern_sched;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] lane_valid, lane_data, lane_clr;
    logic [NL-1:0] lane_ready, lane_ready2;
    logic          det_valid, det_valid2;
    logic [1:0]    det_lane, det_lane2;
    logic [7:0]    det_count;
    logic [1:0]    det_count2;

    lane_pattern_sched #(.NUM_LANES(4), .LANE_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_data(lane_data),
        .lane_ready(lane_ready), .lane_clr(lane_clr), .det_valid(det_valid),
        .det_lane(det_lane), .det_count(det_count)
    );

    lane_pattern_sched #(.NUM_LANES(4), .LANE_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_data(lane_data),
        .lane_ready(lane_ready2), .lane_clr(lane_clr), .det_valid(det_valid2),
        .det_lane(det_lane2), .det_count(det_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lane;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   exp_total = 0;
    int   det_cyc[$];
    bit   sq[NL][$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int lane);
        exp_t e;
        exp_total++;
        e.lane  = lane;
        e.count = (exp_total > 255) ? 255 : exp_total;
        exp_q.push_back(e);
    endtask

    // Monitor: every detection pulse must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (det_valid) begin
            det_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_det_lane", int'(det_lane), -1);
            end else begin
                e = exp_q.pop_front();
                check("det_lane", int'(det_lane), e.lane);
                check("det_count", int'(det_count), e.count);
                check("sat_det_valid", int'(det_valid2), 1);
                check("sat_det_count", int'(det_count2), (e.count > 3) ? 3 : e.count);
            end
        end else if (det_valid2) begin
            check("sat_spurious_det", 1, 0);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers each lane's queued symbols as fast as the DUT accepts them.
    task automatic run_streams(output int stalls, output int last_xfer);
        logic [NL-1:0] xfer;
        bit            done;
        stalls    = 0;
        last_xfer = -1;
        done      = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            done = 1'b1;
            for (int i = 0; i < NL; i++) begin
                lane_valid[i] = (sq[i].size() > 0);
                lane_data[i]  = (sq[i].size() > 0) ? sq[i][0] : 1'b0;
                if (sq[i].size() > 0) done = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                xfer = lane_valid & lane_ready;
                for (int i = 0; i < NL; i++)
                    if (lane_valid[i] && !lane_ready[i]) stalls++;
                if (xfer != '0) last_xfer = cyc;
                @(posedge clk);
                #1;
                for (int i = 0; i < NL; i++)
                    if (xfer[i]) void'(sq[i].pop_front());
            end
        end
        lane_valid = '0;
        lane_data  = '0;
        if (!done) check("stream_budget_expired", 1, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int stalls, lx, base;
        int fair_cnt[NL];
        logic [NL-1:0] x;

        rst        = 1'b0;
        lane_valid = '1;
        lane_data  = '1;
        lane_clr   = '0;

        // Reset held with every lane offering data.
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("reset_ready", int'(lane_ready), 0);
            check("reset_det_valid", int'(det_valid), 0);
            check("reset_det_count", int'(det_count), 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("release_ready_all", int'(lane_ready), 4'hF);
        @(posedge clk); #1;
        @(negedge clk);
        check("first_grant_lane0", int'(lane_ready), 4'h1);
        @(posedge clk); #1;
        lane_valid = '0;
        wait_cycles(6);

        // Reset while lane 2's final Car is held: no detection.
        sq[2] = '{0, 0, 1, 0, 1};
        run_streams(stalls, lx);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_total = 0;
        @(negedge clk);
        check("midreset_no_det", int'(det_valid), 0);
        check("midreset_count", int'(det_count), 0);
        wait_cycles(3);

        // Interleaved lanes 0 and 2 from rr_ptr=0: detections 0 then 2, adjacent.
        base = det_cyc.size();
        push_exp(0);
        push_exp(2);
        sq[0] = '{0, 0, 1, 0, 1};
        sq[2] = '{0, 0, 1, 0, 1};
        run_streams(stalls, lx);
        wait_cycles(5);
        check("interleave_det_num", det_cyc.size() - base, 2);
        if (det_cyc.size() - base == 2)
            check("interleave_adjacent", det_cyc[base+1] - det_cyc[base], 1);

        // Single lane back-to-back.
        base = det_cyc.size();
        push_exp(1);
        sq[1] = '{0, 0, 1, 0, 1};
        run_streams(stalls, lx);
        wait_cycles(4);
        check("single_lane_stalls", stalls, 0);
        check("single_det_num", det_cyc.size() - base, 1);
        if (det_cyc.size() - base == 1)
            check("single_det_latency", det_cyc[base] - lx, 2);
        check("single_count", int'(det_count), 3);

        // Overlap on lane 3: hit only on the 8th symbol.
        base = det_cyc.size();
        push_exp(3);
        sq[3] = '{0, 0, 1, 0, 0, 1, 0, 1};
        run_streams(stalls, lx);
        wait_cycles(4);
        check("overlap_det_num", det_cyc.size() - base, 1);
        if (det_cyc.size() - base == 1)
            check("overlap_det_at_8th", det_cyc[base] - lx, 2);

        base = det_cyc.size();
        push_exp(3);
        sq[3] = '{0, 0, 1, 0, 1, 0, 1};
        run_streams(stalls, lx);
        wait_cycles(4);
        check("restart_det_num", det_cyc.size() - base, 1);
        check("restart_count", int'(det_count), 5);

        // Clear collides with the grant of lane 0's final Car.
        base = det_cyc.size();
        sq[0] = '{0, 0, 1, 0, 1};
        run_streams(stalls, lx);
        lane_clr = 4'b0001;
        @(negedge clk);
        check("clr_blocks_ready", int'(lane_ready[0]), 0);
        @(posedge clk); #1;
        lane_clr = '0;
        wait_cycles(3);
        check("clr_no_det", det_cyc.size() - base, 0);

        sq[0] = '{1, 0, 1};
        run_streams(stalls, lx);
        wait_cycles(4);
        check("after_clr_partial_no_det", det_cyc.size() - base, 0);

        push_exp(0);
        sq[0] = '{0, 0, 1, 0, 1};
        run_streams(stalls, lx);
        wait_cycles(4);
        check("after_clr_fresh_det", det_cyc.size() - base, 1);

        // Fairness: all lanes saturated with Car for 16 granted cycles.
        lane_valid = '1;
        lane_data  = '1;
        @(posedge clk); #1;
        for (int i = 0; i < NL; i++) fair_cnt[i] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            x = lane_valid & lane_ready;
            for (int i = 0; i < NL; i++) fair_cnt[i] += int'(x[i]);
            @(posedge clk); #1;
        end
        lane_valid = '0;
        for (int i = 0; i < NL; i++) check($sformatf("fair_lane%0d", i), fair_cnt[i], 4);
        wait_cycles(8);

        check("final_count", int'(det_count), 6);
        check("final_sat_count", int'(det_count2), 3);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
